// File: rtl/lcd_text_buffer.sv
// ---------------------------------------------------------------------------
// lcd_text_buffer
//
// Purpose
//   Character frame buffer in front of the 16x2 LCD driver. Decoded ASCII
//   characters arrive over a valid/ready handshake. They are written into a
//   2x16 text image that supports auto-wrap, backspace, newline, a
//   multi-cycle scroll and a multi-cycle clear. The image is presented as two
//   128-bit rows. An optional blinking cursor can be overlaid on the rows.
//
// Handshake
//   in_ready is combinational: (state == IDLE) && !clr.
//   A character is consumed on any rising clk edge where in_valid && in_ready.
//   The source must hold in_char stable while in_valid is high and in_ready
//   is low. in_ready never depends on in_valid.
//
// Ports
//   clk       in   1    system clock
//   rst       in   1    asynchronous, active-high reset
//   in_valid  in   1    in_char valid
//   in_char   in   8    ASCII character or control code (0x08 BS, 0x0A LF)
//   in_ready  out  1    buffer can take a character this cycle
//   clr       in   1    clear-screen request, level-sampled every cycle
//   line1     out  128  row 0, char i at [127-8*i -: 8] (registered)
//   line2     out  128  row 1, same packing (registered)
//   cur_row   out  1    cursor row
//   cur_col   out  4    cursor column
//   busy      out  1    a scroll or a clear is in progress
// ---------------------------------------------------------------------------
module lcd_text_buffer #(
  parameter int          BLINK_CYCLES = 25_000_000,
  parameter bit          CURSOR_EN    = 1'b1,
  parameter logic [7:0]  CURSOR_CHAR  = 8'h5F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_char,
  output logic         in_ready,
  input  logic         clr,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic         cur_row,
  output logic [3:0]   cur_col,
  output logic         busy
);

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] LF    = 8'h0A;

  // The blink counter is sized for BLINK_CYCLES-1. BLINK_CYCLES is at least 2.
  localparam int             CW      = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [7:0]    text_mem [32];
  logic [CW-1:0] blink_cnt;
  logic          blink_phase;

  logic [4:0]    pos;
  logic          accept;
  logic          printable;
  logic          show_cursor;
  logic [127:0]  img1;
  logic [127:0]  img2;

  // {row, col} is exactly row*16 + col.
  assign pos       = {cur_row, cur_col};
  assign in_ready  = (state == IDLE) && !clr;
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign printable = (in_char >= 8'h20) && (in_char <= 8'h7E);

  // -------------------------------------------------------------------------
  // Control FSM and text storage.
  // clr has priority over everything, including a pending in_valid. It aborts
  // a scroll and restarts a clear that is already running.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 4'd0;
      cur_row <= 1'b0;
      cur_col <= 4'd0;
      for (int i = 0; i < 32; i++) begin
        text_mem[i] <= SPACE;
      end
    end else if (clr) begin
      state <= CLEAR;
      idx   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (printable) begin
              text_mem[pos] <= in_char;
              if (cur_col != 4'd15) begin
                cur_col <= cur_col + 4'd1;
              end else if (!cur_row) begin
                cur_row <= 1'b1;
                cur_col <= 4'd0;
              end else begin
                // The last cell is full. The character just written at
                // (1,15) is moved to buf[15] by the scroll.
                state <= SCROLL;
                idx   <= 4'd0;
              end
            end else if (in_char == BS) begin
              if (cur_col != 4'd0) begin
                cur_col           <= cur_col - 4'd1;
                text_mem[pos - 5'd1] <= SPACE;
              end else if (cur_row) begin
                cur_row      <= 1'b0;
                cur_col      <= 4'd15;
                text_mem[15] <= SPACE;
              end
            end else if (in_char == LF) begin
              if (!cur_row) begin
                cur_row <= 1'b1;
                cur_col <= 4'd0;
              end else begin
                state <= SCROLL;
                idx   <= 4'd0;
              end
            end
            // Other control codes are consumed and dropped.
          end
        end

        SCROLL: begin
          // Move one column of row 1 up into row 0 on each cycle.
          text_mem[{1'b0, idx}] <= text_mem[{1'b1, idx}];
          text_mem[{1'b1, idx}] <= SPACE;
          idx                   <= idx + 4'd1;
          if (idx == 4'd15) begin
            state   <= IDLE;
            cur_row <= 1'b1;
            cur_col <= 4'd0;
          end
        end

        CLEAR: begin
          text_mem[{1'b0, idx}] <= SPACE;
          text_mem[{1'b1, idx}] <= SPACE;
          idx                   <= idx + 4'd1;
          if (idx == 4'd15) begin
            state   <= IDLE;
            cur_row <= 1'b0;
            cur_col <= 4'd0;
          end
        end

        default: begin
          state <= IDLE;
          idx   <= 4'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Cursor blink. Each accepted character restarts the blink period with the
  // cursor visible, so the cursor does not vanish while the user is typing.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (accept) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Output image. The cursor is only an overlay on the outputs and is never
  // written into text_mem. It is hidden while a scroll or a clear is running.
  // -------------------------------------------------------------------------
  assign show_cursor = CURSOR_EN && blink_phase && (state == IDLE);

  always_comb begin
    img1 = '0;
    img2 = '0;
    for (int i = 0; i < 16; i++) begin
      img1[127 - 8*i -: 8] = (show_cursor && (pos == 5'(i)))      ? CURSOR_CHAR : text_mem[i];
      img2[127 - 8*i -: 8] = (show_cursor && (pos == 5'(16 + i))) ? CURSOR_CHAR : text_mem[16 + i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line1 <= {16{SPACE}};
      line2 <= {16{SPACE}};
    end else begin
      line1 <= img1;
      line2 <= img2;
    end
  end

endmodule
